// File: rtl/axis_skid_register.sv
// AXI-Stream register slice with a two-entry skid buffer: both tvalid and tready
// leave from flops, so neither the forward nor the backward path is combinational.
module axis_skid_register #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1
) (
    input  logic                      clk,
    input  logic                      sresetn,
    output logic                      axis_i_tready,
    input  logic                      axis_i_tvalid,
    input  logic                      axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]   axis_i_tdata,
    input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
    input  logic                      axis_o_tready,
    output logic                      axis_o_tvalid,
    output logic                      axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0] axis_o_tuser
);

    localparam int DATA_W = AXIS_BYTES * 8;
    localparam int BEAT_W = 1 + AXIS_USER_BITS + DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_p1;
    state_t            next_state;
    logic              in_hs;
    logic              out_hs;
    logic              load_out_in;
    logic              load_out_skid;
    logic              load_skid;
    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] out_beat_p1;
    logic [BEAT_W-1:0] skid_beat_p1;

    assign in_beat = {axis_i_tlast, axis_i_tuser, axis_i_tdata};
    assign in_hs   = axis_i_tvalid & axis_i_tready;
    assign out_hs  = axis_o_tvalid & axis_o_tready;

    // Stage p1 control: state plus the two handshake flops derived from next_state
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_p1      <= EMPTY;
            axis_o_tvalid <= 1'b0;
            axis_i_tready <= 1'b0;
        end else begin
            state_p1      <= next_state;
            axis_o_tvalid <= (next_state != EMPTY);
            axis_i_tready <= (next_state != FULL);
        end
    end

    always_comb begin
        next_state = state_p1;
        unique case (state_p1)
            EMPTY: begin
                if (in_hs) next_state = BUSY;
            end
            BUSY: begin
                if (in_hs && !out_hs)      next_state = FULL;
                else if (!in_hs && out_hs) next_state = EMPTY;
            end
            FULL: begin
                if (out_hs) next_state = BUSY;
            end
            default: next_state = EMPTY;
        endcase
    end

    // Data-path load enables; in FULL tready is low so only the skid drains into OUT
    always_comb begin
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state_p1)
            EMPTY: begin
                load_out_in = in_hs;
            end
            BUSY: begin
                load_out_in = in_hs & out_hs;
                load_skid   = in_hs & ~out_hs;
            end
            FULL: begin
                load_out_skid = out_hs;
            end
            default: begin
                load_out_in = 1'b0;
            end
        endcase
    end

    // Stage p1 data: OUT and SKID registers, deliberately not reset
    always_ff @(posedge clk) begin
        if (load_out_in) begin
            out_beat_p1 <= in_beat;
        end else if (load_out_skid) begin
            out_beat_p1 <= skid_beat_p1;
        end
        if (load_skid) begin
            skid_beat_p1 <= in_beat;
        end
    end

    assign {axis_o_tlast, axis_o_tuser, axis_o_tdata} = out_beat_p1;

endmodule

// File: tb/tb_axis_skid_register.sv
// Bench for axis_skid_register: vector tables for streaming and stall cases, a
// beat scoreboard and an output-stability monitor running on every cycle.
module tb_axis_skid_register;

    logic       clk = 1'b0;
    logic       sresetn = 1'b0;
    logic       i_tready;
    logic       i_tvalid = 1'b0;
    logic       i_tlast = 1'b0;
    logic [7:0] i_tdata = 8'd0;
    logic [0:0] i_tuser = 1'b0;
    logic       o_tready = 1'b0;
    logic       o_tvalid;
    logic       o_tlast;
    logic [7:0] o_tdata;
    logic [0:0] o_tuser;

    always #5 clk = ~clk;

    axis_skid_register #(
        .AXIS_BYTES    (1),
        .AXIS_USER_BITS(1)
    ) dut (
        .clk          (clk),
        .sresetn      (sresetn),
        .axis_i_tready(i_tready),
        .axis_i_tvalid(i_tvalid),
        .axis_i_tlast (i_tlast),
        .axis_i_tdata (i_tdata),
        .axis_i_tuser (i_tuser),
        .axis_o_tready(o_tready),
        .axis_o_tvalid(o_tvalid),
        .axis_o_tlast (o_tlast),
        .axis_o_tdata (o_tdata),
        .axis_o_tuser (o_tuser)
    );

    typedef struct {
        logic       vld;
        logic       ordy;
        logic       exp_irdy;
        logic       exp_ovld;
        logic [7:0] exp_odata;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] next_data = 8'd0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat = 10'd0;
    logic       obs_irdy;
    logic       obs_ovld;
    logic       obs_hs_in;
    logic [7:0] obs_odata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic vld, input logic ordy, input logic irdy,
                       input logic ovld, input logic [7:0] odata);
        vec_t v;
        v.vld = vld; v.ordy = ordy; v.exp_irdy = irdy; v.exp_ovld = ovld; v.exp_odata = odata;
        tbl.push_back(v);
    endtask

    // One clock cycle: drive after negedge, observe 1 time unit later, scoreboard the handshakes
    task automatic step(input logic rstn, input logic vld, input logic ordy);
        logic [9:0] beat;
        logic [9:0] exp_beat;
        @(negedge clk);
        sresetn  = rstn;
        i_tvalid = vld;
        i_tdata  = next_data;
        i_tlast  = (next_data[3:0] == 4'hF);
        i_tuser  = next_data[0];
        o_tready = ordy;
        #1;
        beat      = {o_tlast, o_tuser, o_tdata};
        obs_irdy  = i_tready;
        obs_ovld  = o_tvalid;
        obs_odata = o_tdata;
        obs_hs_in = vld & i_tready;
        if (prev_stall) chk("stall_stable", 32'({o_tvalid, beat}), 32'({1'b1, prev_beat}));
        if (!rstn) begin
            sb.delete();
            prev_stall = 1'b0;
            obs_hs_in  = 1'b0;
        end else begin
            if (o_tvalid && ordy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_beat actual=%0h required=none", beat);
                end else begin
                    exp_beat = sb.pop_front();
                    chk("sb_beat", 32'(beat), 32'(exp_beat));
                end
            end
            if (obs_hs_in) begin
                sb.push_back({i_tlast, i_tuser, i_tdata});
                next_data = next_data + 8'd1;
            end
            prev_stall = o_tvalid & ~ordy;
            prev_beat  = beat;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepts;
        int cycles;

        // Streaming 0x00..0x0F, then single-cycle stall while 0x13 is on the output
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 15; k++) add(1'b1, 1'b1, 1'b1, 1'b1, 8'(k - 1));
        add(1'b0, 1'b1, 1'b1, 1'b1, 8'h0F);
        add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 1'b1, 8'h10);
        add(1'b1, 1'b1, 1'b1, 1'b1, 8'h11);
        add(1'b1, 1'b1, 1'b1, 1'b1, 8'h12);
        add(1'b1, 1'b0, 1'b1, 1'b1, 8'h13);
        add(1'b1, 1'b1, 1'b0, 1'b1, 8'h13);
        add(1'b1, 1'b1, 1'b1, 1'b1, 8'h14);
        for (int k = 7; k <= 16; k++) add(1'b1, 1'b1, 1'b1, 1'b1, 8'(8'h10 + k - 2));
        add(1'b0, 1'b1, 1'b1, 1'b1, 8'h1F);
        add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

        // Reset hold with tvalid asserted, then release
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("rst_irdy", 32'(obs_irdy), 32'd0);
            chk("rst_ovld", 32'(obs_ovld), 32'd0);
        end
        step(1'b1, 1'b0, 1'b1);
        chk("rel_irdy_before_edge", 32'(obs_irdy), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("rel_irdy", 32'(obs_irdy), 32'd1);
        chk("rel_ovld", 32'(obs_ovld), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b1, tbl[i].vld, tbl[i].ordy);
            chk($sformatf("tbl%0d_irdy", i), 32'(obs_irdy), 32'(tbl[i].exp_irdy));
            chk($sformatf("tbl%0d_ovld", i), 32'(obs_ovld), 32'(tbl[i].exp_ovld));
            if (tbl[i].exp_ovld) chk($sformatf("tbl%0d_odata", i), 32'(obs_odata), 32'(tbl[i].exp_odata));
        end

        // Long stall: exactly two beats accepted, tready low afterwards
        accepts = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b1, 1'b0);
            if (obs_hs_in) accepts++;
            if (c >= 2) chk("long_irdy", 32'(obs_irdy), 32'd0);
        end
        chk("long_accepts", 32'(accepts), 32'd2);
        step(1'b1, 1'b1, 1'b1);
        chk("long_rel0_odata", 32'(obs_odata), 32'h20);
        chk("long_rel0_irdy", 32'(obs_irdy), 32'd0);
        step(1'b1, 1'b1, 1'b1);
        chk("long_rel1_odata", 32'(obs_odata), 32'h21);
        chk("long_rel1_irdy", 32'(obs_irdy), 32'd1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1);
        chk("long_drained_ovld", 32'(obs_ovld), 32'd0);
        chk("long_drained_sb", 32'(sb.size()), 32'd0);

        // Randomised handshakes over 10000 accepted beats
        accepts = 0;
        cycles  = 0;
        while (accepts < 10000 && cycles < 60000) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (obs_hs_in) accepts++;
            cycles++;
        end
        chk("rand_beats_done", 32'(accepts >= 10000), 32'd1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1);
        chk("rand_drained_ovld", 32'(obs_ovld), 32'd0);
        chk("rand_drained_sb", 32'(sb.size()), 32'd0);

        // Mid-operation reset while FULL
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("mid_full_irdy", 32'(obs_irdy), 32'd0);
        chk("mid_full_ovld", 32'(obs_ovld), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("mid_post_ovld", 32'(obs_ovld), 32'd0);
        chk("mid_post_irdy", 32'(obs_irdy), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("mid_irdy_up", 32'(obs_irdy), 32'd1);
        chk("mid_no_stale", 32'(obs_ovld), 32'd0);
        next_data = 8'hA5;
        step(1'b1, 1'b1, 1'b1);
        chk("mid_a5_accept", 32'(obs_hs_in), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("mid_a5_ovld", 32'(obs_ovld), 32'd1);
        chk("mid_a5_odata", 32'(obs_odata), 32'hA5);
        step(1'b1, 1'b0, 1'b1);
        chk("mid_a5_alone", 32'(obs_ovld), 32'd0);
        chk("mid_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
